// File: rtl/chip8_alu_seq.sv
// CHIP-8 execute-stage sequencer: owns V0-VF, issues 6XNN/7XNN/8XYN
// to a clocked ALU, waits out its latency and writes back Vx and VF.
module chip8_alu_seq #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    output logic [3:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic        alu_err,
    output logic        done,
    output logic        err,
    input  logic [3:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        FLAG,
        REJECT
    } state_t;

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];
    logic [7:0]  op1_q, op1_d;
    logic [7:0]  op2_q, op2_d;
    logic [3:0]  opc_q, opc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic        pend_q, pend_d;
    logic        perr_q, perr_d;
    logic        done_q, err_q;

    logic [3:0] top, rx, ry, rn;
    logic [7:0] nn;
    logic       flag_op;

    assign top = ir_q[15:12];
    assign rx  = ir_q[11:8];
    assign ry  = ir_q[7:4];
    assign rn  = ir_q[3:0];
    assign nn  = ir_q[7:0];

    always_comb begin
        flag_op = 1'b0;
        if (top == 4'h8) begin
            unique case (rn)
                4'h4, 4'h5, 4'h6, 4'h7, 4'hE: flag_op = 1'b1;
                default:                      flag_op = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        pend_d  = 1'b0;
        perr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    ir_d = instr;
                    unique case (instr[15:12])
                        4'h6:       state_d = WB;
                        4'h7, 4'h8: state_d = ISSUE;
                        default:    state_d = REJECT;
                    endcase
                end
            end
            ISSUE: begin
                op1_d   = regs_q[rx];
                op2_d   = (top == 4'h7) ? nn : regs_q[ry];
                opc_d   = (top == 4'h7) ? 4'h4 : rn;
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = WB;
                end
            end
            WB: begin
                if (top == 4'h6) begin
                    regs_d[rx] = nn;
                    pend_d     = 1'b1;
                    state_d    = IDLE;
                end else if (top == 4'h8 && alu_err) begin
                    pend_d  = 1'b1;
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    regs_d[rx] = alu_out;
                    carry_d    = alu_carry;
                    if (flag_op) begin
                        state_d = FLAG;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            // VF write lands after WB so the flag wins when X==F
            FLAG: begin
                regs_d[15] = {7'b0, carry_q};
                pend_d     = 1'b1;
                state_d    = IDLE;
            end
            REJECT: begin
                pend_d  = 1'b1;
                perr_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            pend_q  <= 1'b0;
            perr_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            regs_q  <= regs_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            pend_q  <= pend_d;
            perr_q  <= perr_d;
            done_q  <= pend_q;
            err_q   <= perr_q;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_opcode  = opc_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Scoreboard bench for chip8_alu_seq: two DUTs (ALU latency 1 and 3),
// each with a behavioural pipelined ALU, checked against a register model.
module tb_chip8_alu_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] instr;
    logic [1:0]  vld, rdy, dn, er, acar, aerr;
    logic [7:0]  op1 [2];
    logic [7:0]  op2 [2];
    logic [7:0]  aout [2];
    logic [7:0]  dbg [2];
    logic [3:0]  opc [2];
    logic [3:0]  dbg_addr;

    int sel;
    int tests;
    int fails;

    typedef struct {
        logic [15:0] ins;
        logic        e;
        int          lat;
        time         t;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mv [16];

    function automatic logic [9:0] alu_f(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        logic [8:0] s;
        case (op)
            4'h0: return {2'b00, b};
            4'h1: return {2'b00, a | b};
            4'h2: return {2'b00, a & b};
            4'h3: return {2'b00, a ^ b};
            4'h4: begin
                s = {1'b0, a} + {1'b0, b};
                return {1'b0, s[8], s[7:0]};
            end
            4'h5: return {1'b0, a >= b, 8'(a - b)};
            4'h6: return {1'b0, a[0], 8'(a >> 1)};
            4'h7: return {1'b0, b >= a, 8'(b - a)};
            4'hE: return {1'b0, a[7], 8'(a << 1)};
            default: return {2'b10, 8'h00};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [9:0] pipe [L];
        exp_t       e;
        int         lat;

        chip8_alu_seq #(.ALU_LATENCY(L)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .instr       (instr),
            .instr_valid (vld[g]),
            .instr_ready (rdy[g]),
            .alu_op1     (op1[g]),
            .alu_op2     (op2[g]),
            .alu_opcode  (opc[g]),
            .alu_out     (aout[g]),
            .alu_carry   (acar[g]),
            .alu_err     (aerr[g]),
            .done        (dn[g]),
            .err         (er[g]),
            .dbg_addr    (dbg_addr),
            .dbg_data    (dbg[g])
        );

        always @(posedge clk) begin
            pipe[0] <= alu_f(op1[g], op2[g], opc[g]);
            for (int i = 1; i < L; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end

        assign {aerr[g], acar[g], aout[g]} = pipe[L-1];

        always @(negedge clk) begin
            if (rst_n && (dn[g] || er[g])) begin
                tests++;
                if (g != sel) begin
                    fails++;
                    $display("FAIL stray_retire inst=%0d done=%b err=%b want idle", g, dn[g], er[g]);
                end else if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_retire L=%0d done=%b err=%b want none", L, dn[g], er[g]);
                end else begin
                    e = q.pop_front();
                    lat = int'(($time - e.t - 5) / 10);
                    if (dn[g] !== 1'b1 || er[g] !== e.e || lat != e.lat) begin
                        fails++;
                        $display("FAIL retire L=%0d instr=%h got done=%b err=%b lat=%0d want done=1 err=%b lat=%0d",
                                 L, e.ins, dn[g], er[g], lat, e.e, e.lat);
                    end
                end
            end
        end
    end

    function automatic int cur_lat();
        return (sel == 0) ? 1 : 3;
    endfunction

    task automatic model_exec(input logic [15:0] ins, output logic e, output int lat);
        int x, y, n, nn, vx, vy, r, f;
        x  = int'(ins[11:8]);
        y  = int'(ins[7:4]);
        n  = int'(ins[3:0]);
        nn = int'(ins[7:0]);
        vx = int'(mv[x]);
        vy = int'(mv[y]);
        r  = 0;
        f  = -1;
        e  = 1'b0;
        case (ins[15:12])
            4'h6: begin
                mv[x] = 8'(nn);
                lat = 2;
            end
            4'h7: begin
                mv[x] = 8'((vx + nn) % 256);
                lat = 3 + cur_lat();
            end
            4'h8: begin
                lat = 3 + cur_lat();
                case (n)
                    0:  r = vy;
                    1:  r = vx | vy;
                    2:  r = vx & vy;
                    3:  r = vx ^ vy;
                    4:  begin r = vx + vy; f = (r > 255) ? 1 : 0; end
                    5:  begin r = vx - vy; f = (vx >= vy) ? 1 : 0; end
                    6:  begin r = vx / 2;  f = vx % 2; end
                    7:  begin r = vy - vx; f = (vy >= vx) ? 1 : 0; end
                    14: begin r = vx * 2;  f = vx / 128; end
                    default: e = 1'b1;
                endcase
                if (!e) begin
                    mv[x] = 8'(r & 255);
                    if (f >= 0) begin
                        mv[15] = 8'(f);
                        lat = 4 + cur_lat();
                    end
                end
            end
            default: begin
                e = 1'b1;
                lat = 2;
            end
        endcase
    endtask

    task automatic issue(input logic [15:0] ins, input bit push);
        exp_t e;
        int n;
        @(negedge clk);
        instr = ins;
        vld = 2'b01 << sel;
        n = 0;
        while (!rdy[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[sel]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout instr=%h ready=%b want 1", ins, rdy[sel]);
            vld = 2'b00;
            return;
        end
        @(posedge clk);
        e.t = $time;
        e.ins = ins;
        model_exec(ins, e.e, e.lat);
        if (push) q.push_back(e);
        @(negedge clk);
        vld = 2'b00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL retire_timeout pending=%0d want 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            tests++;
            if (dbg[sel] !== mv[i]) begin
                fails++;
                $display("FAIL %s L=%0d V%h got %h want %h", tag, cur_lat(), i, dbg[sel], mv[i]);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        tests++;
        if (rdy[sel] !== 1'b1 || dn[sel] !== 1'b0 || er[sel] !== 1'b0) begin
            fails++;
            $display("FAIL %s L=%0d ready=%b done=%b err=%b want 1 0 0",
                     tag, cur_lat(), rdy[sel], dn[sel], er[sel]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 8'h00;
    endtask

    task automatic run_suite();
        logic [15:0] dir [20];
        logic [15:0] ins;
        int k;
        dir = '{16'h6AFF, 16'h6B01, 16'h8AB4, 16'h6A05, 16'h6B07, 16'h8AB5,
                16'h6A07, 16'h6B05, 16'h8AB5, 16'h6F80, 16'h6A01, 16'h8FAE,
                16'h6AFF, 16'h6F55, 16'h7A01, 16'h6A3C, 16'h6B0F, 16'h8AB2,
                16'h8AB9, 16'h5AB0};
        do_reset();
        #1;
        check_idle("reset_flags");
        tests++;
        if (op1[sel] !== 8'h00 || op2[sel] !== 8'h00 || opc[sel] !== 4'h0) begin
            fails++;
            $display("FAIL reset_alu_ops got %h %h %h want 00 00 0", op1[sel], op2[sel], opc[sel]);
        end
        check_regs("reset_regs");

        foreach (dir[i]) begin
            issue(dir[i], 1'b1);
            wait_idle();
            check_regs("directed");
        end

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 4);
            ins[11:0] = 12'($urandom);
            case (k)
                0:       ins[15:12] = 4'h6;
                1:       ins[15:12] = 4'h7;
                2, 3:    ins[15:12] = 4'h8;
                default: ins[15:12] = 4'($urandom_range(9, 15));
            endcase
            issue(ins, 1'b1);
            wait_idle();
            check_regs("random");
        end

        issue(16'h6A11, 1'b1);
        wait_idle();
        check_regs("pre_abort");
        issue(16'h8AB4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("abort_in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 8'h00;
        #1;
        check_idle("abort_release");
        repeat (8) @(negedge clk);
        check_idle("abort_quiet");
        check_regs("abort_regs");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vld = 2'b00;
        instr = 16'h0000;
        dbg_addr = 4'h0;
        sel = 0;
        tests = 0;
        fails = 0;
        run_suite();
        sel = 1;
        run_suite();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
